// File: rtl/genie_demux.sv
`default_nettype none
// ============================================================================
// Module      : genie_demux
// Description : Registered packet-aware stream demultiplexer. The selector is
//               captured on each head beat and held for the rest of the packet;
//               packets to nonexistent outputs are sunk and flagged.
//               Optional: GENIE_DEMUX_DROP_COUNT_EN adds o_drop_count.
// Revision    : 1.0 - initial release
// ============================================================================
module genie_demux #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 4,
    parameter int SELW  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  i_data,
    input  logic [SELW-1:0]   i_sel,
    input  logic              i_eop,
    input  logic              i_valid,
    output logic              i_ready,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_eop,
    output logic [SIZE-1:0]   o_valid,
    input  logic [SIZE-1:0]   o_ready,
`ifdef GENIE_DEMUX_DROP_COUNT_EN
    output logic [15:0]       o_drop_count,
`endif
    output logic              o_drop
);

    localparam logic [1:0] c_ST_HEAD = 2'd0;
    localparam logic [1:0] c_ST_BODY = 2'd1;
    localparam logic [1:0] c_ST_DROP = 2'd2;

    // One extra bit so SIZE == 2**SELW is representable in the range compare.
    localparam logic [SELW:0] c_SIZE_EXT = (SELW + 1)'(SIZE);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_full;
    logic [SELW-1:0]  r_dest;
    logic [SELW-1:0]  r_pkt_dest;
    logic [WIDTH-1:0] r_data;
    logic             r_eop;
    logic             r_drop;

    logic             w_dest_ready;
    logic             w_drain;
    logic             w_accept;
    logic             w_sel_ok;
    logic             w_load;
    logic             w_drop_start;
    logic [SELW-1:0]  w_load_dest;

    // Ready of the currently addressed output, bounded to existing outputs.
    always_comb begin
        w_dest_ready = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (r_dest == SELW'(i)) begin
                w_dest_ready = o_ready[i];
            end
        end
    end

    assign w_drain = r_full && w_dest_ready;

    always_comb begin
        if (!reset_n) begin
            i_ready = 1'b0;
        end else if (r_state == c_ST_DROP) begin
            i_ready = 1'b1;
        end else begin
            i_ready = !r_full || w_dest_ready;
        end
    end

    assign w_accept     = i_valid && i_ready;
    assign w_sel_ok     = ({1'b0, i_sel} < c_SIZE_EXT);
    assign w_load       = w_accept && ((r_state == c_ST_BODY) ||
                                       ((r_state == c_ST_HEAD) && w_sel_ok));
    assign w_drop_start = w_accept && (r_state == c_ST_HEAD) && !w_sel_ok;
    assign w_load_dest  = (r_state == c_ST_BODY) ? r_pkt_dest : i_sel;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_HEAD: begin
                if (w_accept && !i_eop) begin
                    w_state_nxt = w_sel_ok ? c_ST_BODY : c_ST_DROP;
                end
            end
            c_ST_BODY,
            c_ST_DROP: begin
                if (w_accept && i_eop) begin
                    w_state_nxt = c_ST_HEAD;
                end
            end
            default: w_state_nxt = c_ST_HEAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_HEAD;
            r_pkt_dest <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_start;
            if (w_accept && (r_state == c_ST_HEAD) && w_sel_ok) begin
                r_pkt_dest <= i_sel;
            end
        end
    end

    // Output stage: a load in the same cycle as a drain replaces the old beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_dest <= '0;
            r_data <= '0;
            r_eop  <= 1'b0;
        end else begin
            if (w_load) begin
                r_full <= 1'b1;
                r_dest <= w_load_dest;
                r_data <= i_data;
                r_eop  <= i_eop;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_valid
            assign o_valid[gi] = r_full && (r_dest == SELW'(gi));
        end
    endgenerate

    assign o_data = r_data;
    assign o_eop  = r_eop;
    assign o_drop = r_drop;

`ifdef GENIE_DEMUX_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= 16'h0000;
        end else if (w_drop_start && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'h0001;
        end
    end

    assign o_drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_genie_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_genie_demux
// Description : Directed scoreboard bench for genie_demux (SIZE=3, SELW=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_genie_demux;

    logic        clk;
    logic        reset_n;
    logic [31:0] i_data;
    logic [1:0]  i_sel;
    logic        i_eop;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_eop;
    logic [2:0]  o_valid;
    logic [2:0]  o_ready;
    logic        o_drop;
`ifdef GENIE_DEMUX_DROP_COUNT_EN
    logic [15:0] o_drop_count;
`endif

    genie_demux #(.WIDTH(32), .SIZE(3), .SELW(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_data       (i_data),
        .i_sel        (i_sel),
        .i_eop        (i_eop),
        .i_valid      (i_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_eop        (o_eop),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
`ifdef GENIE_DEMUX_DROP_COUNT_EN
        .o_drop_count (o_drop_count),
`endif
        .o_drop       (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  dest;
        logic        eop;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    int    checks     = 0;
    int    failures   = 0;
    int    drops_seen = 0;
    int    exp_drops  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output side: every beat that leaves must match the oldest expected beat.
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_drop) drops_seen++;
            if ((o_valid & o_ready) != 3'b000) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", {61'd0, o_valid}, 64'd0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("out_valid", {61'd0, o_valid}, {61'd0, 3'b001 << e.dest});
                    check("out_data", {32'd0, o_data}, {32'd0, e.data});
                    check("out_eop", {63'd0, o_eop}, {63'd0, e.eop});
                end
            end
        end
    end

    // Drives one beat from posedge+1, returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [31:0] d, input logic [1:0] s, input logic e,
                             input logic [1:0] exp_dest, input logic exp_drop,
                             output int waited);
        i_data  = d;
        i_sel   = s;
        i_eop   = e;
        i_valid = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!i_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        check("accept", {63'd0, i_ready}, 64'd1);
        if (i_ready && !exp_drop) sb.push_back({exp_dest, e, d});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        reset_n = 1'b0;
        i_data  = '0;
        i_sel   = '0;
        i_eop   = 1'b0;
        i_valid = 1'b0;
        o_ready = 3'b111;

        // Reset state
        repeat (2) @(negedge clk);
        i_valid = 1'b1;
        #1;
        check("rst_i_ready", {63'd0, i_ready}, 64'd0);
        check("rst_o_valid", {61'd0, o_valid}, 64'd0);
        check("rst_o_data", {32'd0, o_data}, 64'd0);
        check("rst_o_eop", {63'd0, o_eop}, 64'd0);
        check("rst_o_drop", {63'd0, o_drop}, 64'd0);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);

        // Basic routing: 3 beats to output 2
        send_beat(32'h11, 2'd2, 1'b0, 2'd2, 1'b0, w);
        send_beat(32'h22, 2'd2, 1'b0, 2'd2, 1'b0, w);
        send_beat(32'h33, 2'd2, 1'b1, 2'd2, 1'b0, w);
        @(negedge clk);
        check("basic_last_valid", {61'd0, o_valid}, 64'b100);
        check("basic_last_eop", {63'd0, o_eop}, 64'd1);
        idle(2);

        // Selector changes mid-packet are ignored
        send_beat(32'h11, 2'd2, 1'b0, 2'd2, 1'b0, w);
        send_beat(32'h22, 2'd1, 1'b0, 2'd2, 1'b0, w);
        send_beat(32'h33, 2'd1, 1'b1, 2'd2, 1'b0, w);
        // Back-to-back single-beat packets to different outputs
        send_beat(32'hC0, 2'd0, 1'b1, 2'd0, 1'b0, w);
        send_beat(32'hC1, 2'd1, 1'b1, 2'd1, 1'b0, w);
        check("b2b_no_stall", w, 64'd0);
        idle(2);

        // Backpressure on output 2 while output 0 is ready
        o_ready = 3'b001;
        send_beat(32'hA1, 2'd2, 1'b0, 2'd2, 1'b0, w);
        i_data  = 32'hB2;
        i_sel   = 2'd0;
        i_eop   = 1'b1;
        i_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_i_ready", {63'd0, i_ready}, 64'd0);
            check("bp_o_data_held", {32'd0, o_data}, 64'hA1);
            check("bp_o_valid_held", {61'd0, o_valid}, 64'b100);
            @(posedge clk);
            #1;
        end
        o_ready = 3'b111;
        @(negedge clk);
        check("bp_release_ready", {63'd0, i_ready}, 64'd1);
        if (i_ready) sb.push_back({2'd2, 1'b1, 32'hB2});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("bp_next_loaded", {32'd0, o_data}, 64'hB2);
        idle(2);

        // Invalid destination: 4-beat packet to output 3 (SIZE=3)
        send_beat(32'hD0, 2'd3, 1'b0, 2'd0, 1'b1, w);
        exp_drops++;
        check("drop_head_no_wait", w, 64'd0);
        @(negedge clk);
        check("drop_pulse", {63'd0, o_drop}, 64'd1);
        check("drop_no_valid", {61'd0, o_valid}, 64'd0);
        check("drop_i_ready", {63'd0, i_ready}, 64'd1);
        @(posedge clk);
        #1;
        send_beat(32'hD1, 2'd0, 1'b0, 2'd0, 1'b1, w);
        check("drop_body_no_wait", w, 64'd0);
        send_beat(32'hD2, 2'd1, 1'b0, 2'd0, 1'b1, w);
        send_beat(32'hD3, 2'd0, 1'b1, 2'd0, 1'b1, w);
        @(negedge clk);
        check("drop_pulse_once", {63'd0, o_drop}, 64'd0);
        check("drop_body_no_valid", {61'd0, o_valid}, 64'd0);
`ifdef GENIE_DEMUX_DROP_COUNT_EN
        check("drop_count_1", {48'd0, o_drop_count}, 64'd1);
`endif
        @(posedge clk);
        #1;
        send_beat(32'h77, 2'd0, 1'b1, 2'd0, 1'b0, w);
        @(negedge clk);
        check("after_drop_route", {61'd0, o_valid}, 64'b001);
        idle(2);

        // Reset mid-packet
        send_beat(32'h41, 2'd1, 1'b0, 2'd1, 1'b0, w);
        send_beat(32'h42, 2'd1, 1'b0, 2'd1, 1'b0, w);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_o_valid", {61'd0, o_valid}, 64'd0);
        check("midrst_i_ready", {63'd0, i_ready}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        send_beat(32'h55, 2'd0, 1'b1, 2'd0, 1'b0, w);
        @(negedge clk);
        check("midrst_new_head", {61'd0, o_valid}, 64'b001);
        idle(2);

`ifdef GENIE_DEMUX_DROP_COUNT_EN
        // Counter saturation: the earlier drop was cleared by reset
        i_sel   = 2'd3;
        i_eop   = 1'b1;
        i_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        exp_drops += 65535;
        @(negedge clk);
        check("sat_count", {48'd0, o_drop_count}, 64'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        exp_drops += 3;
        i_valid = 1'b0;
        @(negedge clk);
        check("sat_hold", {48'd0, o_drop_count}, 64'hFFFF);
        idle(2);
`endif

        check("sb_empty", sb.size(), 64'd0);
        check("drop_pulses", drops_seen, exp_drops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
